wb_cart_bank: RTL
=================

WB_CART_BANK -- requirements
Module: wb_cart_bank

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, number of 4 KB ROM banks; legal values 2 (F8 scheme) and 4 (F6 scheme).
REQ-002 SHALL have parameter RESET_BANK, default NUM_BANKS-1, bank selected after reset.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports stb_i input 1, we_i input 1, adr_i input 12, dat_i input 8: Wishbone slave request from the bus for the F000-FFFF window.
REQ-006 SHALL have ports ack_o output 1, dat_o output 8: slave acknowledge and read data.
REQ-007 SHALL have ports rom_stb_o output 1, rom_adr_o output 14: master request to the downstream ROM.
REQ-008 SHALL have ports rom_ack_i input 1, rom_dat_i input 8: downstream ROM acknowledge and data.
REQ-009 SHALL have port bank_o  output 2  currently selected bank, for debug LEDs.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, ROM, RESP.
REQ-011 In IDLE with stb_i=1, requests served locally SHALL go to RESP next cycle; all other requests SHALL go to ROM. Locally served: any write; Superchip RAM access when enabled.
REQ-012 In ROM, rom_stb_o SHALL be 1 and rom_adr_o SHALL be {bank, adr_i}, with bank zero-extended to 2 bits.
REQ-013 In ROM, rom_dat_i SHALL be registered into dat_o on rom_ack_i=1, and the FSM SHALL go to RESP; without rom_ack_i, the FSM SHALL stay in ROM with no timeout.
REQ-014 In RESP, ack_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-015 Minimum latency stb_i to ack_o: locally served = 1 cycle; ROM = 2 cycles plus ROM wait.
REQ-016 stb_i SHALL be sampled only in IDLE; a master holding stb_i through RESP SHALL NOT start a second transaction until the cycle after RESP.
REQ-017 Hotspots for NUM_BANKS=2: adr_i FF8 selects bank 0; adr_i FF9 selects bank 1.
REQ-018 Hotspots for NUM_BANKS=4: adr_i FF6, FF7, FF8, FF9 select banks 0, 1, 2, 3.
REQ-019 A read or write to a hotspot SHALL switch the bank.
REQ-020 The bank update SHALL occur in the RESP cycle, so a hotspot read returns the byte from the bank selected before the access.
REQ-021 A write to non-hotspot ROM space SHALL be acked with no ROM access and no state change.
REQ-022 A hotspot access to the already-selected bank SHALL leave the bank unchanged.
REQ-023 rom_adr_o SHALL be held stable for the whole ROM state.
REQ-024 dat_o SHALL hold its last value outside RESP.

Reset
REQ-025 On rst_i=0 at a clock edge: FSM=IDLE, ack_o=0, rom_stb_o=0, rom_adr_o=0, dat_o=0, bank=RESET_BANK.
REQ-026 Reset mid-transaction in the ROM or RESP state SHALL abort the transaction with no ack_o; a late rom_ack_i after reset SHALL be ignored.
REQ-027 Superchip RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro CART_SUPERCHIP_EN controls the 128-byte Superchip RAM.
REQ-029 With CART_SUPERCHIP_EN defined, the Superchip RAM SHALL be internal to this block. Writes to adr_i 000-07F store dat_i. Reads of adr_i 080-0FF return byte adr_i[6:0]. Both SHALL be served locally with 1-cycle latency and no rom_stb_o. Reads of 000-07F SHALL return FF.
REQ-030 Without the macro, adr_i 000-0FF SHALL map to ROM like any other address, and no RAM SHALL be instantiated.

Verification
REQ-031 After reset with NUM_BANKS=2, read adr_i 123 with the ROM model acking after 3 cycles -> rom_adr_o=1123; ack_o 5 cycles after stb_i; dat_o equals model byte; bank_o=1.
REQ-032 With NUM_BANKS=2, read FF8 then read 010 -> first read served at rom_adr_o=1FF8; second read at rom_adr_o=0010; bank_o=0 after the first ack.
REQ-033 With NUM_BANKS=4, write AA to FF7 -> ack_o 1 cycle after stb_i; rom_stb_o stays 0; bank_o=1. A following read of 800 -> rom_adr_o=1800.
REQ-034 Assert rst_i=0 while in ROM, then pulse rom_ack_i -> ack_o never asserted; bank_o=RESET_BANK; FSM accepts the next stb_i normally.
REQ-035 With CART_SUPERCHIP_EN: write 5A to 013, then read 093 -> dat_o=5A; 1-cycle latency; no rom_stb_o. Without the macro: the same read -> rom_stb_o=1, rom_adr_o=1093.
REQ-036 Hold stb_i=1 continuously for a ROM read -> exactly one ack_o per transaction; a second transaction starts the cycle after RESP.

Source files
------------

// File: rtl/wb_cart_bank.sv
// Wishbone slave for the F000-FFFF cartridge window: F8/F6 hotspot bank switching in front of a downstream ROM.
// Optional 128-byte Superchip RAM is enabled with the CART_SUPERCHIP_EN macro.
module wb_cart_bank #(
    parameter int NUM_BANKS  = 2,
    parameter int RESET_BANK = NUM_BANKS - 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [11:0] adr_i,
    input  logic [7:0]  dat_i,
    output logic        ack_o,
    output logic [7:0]  dat_o,
    output logic        rom_stb_o,
    output logic [13:0] rom_adr_o,
    input  logic        rom_ack_i,
    input  logic [7:0]  rom_dat_i,
    output logic [1:0]  bank_o
);
    typedef enum logic [1:0] {S_IDLE, S_ROM, S_RESP} state_t;

    // Hotspots occupy the NUM_BANKS addresses ending at FF9.
    localparam logic [11:0] HOT_BASE = 12'(12'hFFA - NUM_BANKS);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_bank;
    logic [11:0] r_adr;
    logic [13:0] r_rom_adr;
    logic [7:0]  r_dat;
    logic        w_accept;
    logic        w_local;
    logic        w_local_rd;
    logic [7:0]  w_local_dat;
    logic [11:0] w_hot_off;
    logic        w_hot_hit;

    assign w_accept = (r_state == S_IDLE) && stb_i;

`ifdef CART_SUPERCHIP_EN
    logic [7:0] r_ram [128];
    logic       w_ram_sel;

    assign w_ram_sel   = (adr_i[11:8] == 4'h0);
    assign w_local     = we_i | w_ram_sel;
    assign w_local_rd  = !we_i && w_ram_sel;
    assign w_local_dat = adr_i[7] ? r_ram[adr_i[6:0]] : 8'hFF;

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (rst_i && w_accept && we_i && (adr_i[11:7] == 5'h00)) begin
            r_ram[adr_i[6:0]] <= dat_i;
        end
    end
`else
    logic w_unused_dat;

    assign w_unused_dat = ^dat_i;
    assign w_local      = we_i;
    assign w_local_rd   = 1'b0;
    assign w_local_dat  = 8'h00;
`endif

    assign w_hot_off = r_adr - HOT_BASE;
    assign w_hot_hit = (w_hot_off < 12'(NUM_BANKS));

    always_comb begin
        w_next    = r_state;
        ack_o     = 1'b0;
        rom_stb_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (stb_i) begin
                    w_next = w_local ? S_RESP : S_ROM;
                end
            end
            S_ROM: begin
                rom_stb_o = 1'b1;
                if (rom_ack_i) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                ack_o  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_bank    <= 2'(RESET_BANK);
            r_adr     <= 12'h000;
            r_rom_adr <= 14'h0000;
            r_dat     <= 8'h00;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_adr <= adr_i;
                if (!w_local) begin
                    r_rom_adr <= {r_bank, adr_i};
                end
                if (w_local_rd) begin
                    r_dat <= w_local_dat;
                end
            end
            if ((r_state == S_ROM) && rom_ack_i) begin
                r_dat <= rom_dat_i;
            end
            // Switch late so a hotspot read still returns data from the old bank.
            if ((r_state == S_RESP) && w_hot_hit) begin
                r_bank <= w_hot_off[1:0];
            end
        end
    end

    assign rom_adr_o = r_rom_adr;
    assign dat_o     = r_dat;
    assign bank_o    = r_bank;
endmodule
